// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state types and the
// address-window decode helper used by the memory responder.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'b00,
        W_GOT_AW = 2'b01,
        W_GOT_W  = 2'b10,
        W_RESP   = 2'b11
    } wstate_t;

    // True when addr falls inside [base, base+span). The offset wraps at
    // 32 bits, so the lower bound is checked separately.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span
    );
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ({1'b0, off} < span);
    endfunction

endpackage

// File: rtl/axi_lite_mem_array.sv
// Word array with four byte-lane write enables and one registered read port.
// A read and a write to the same word on the same edge returns the old word.
module axi_lite_mem_array #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [3:0]            i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic                  i_rd_en,
    input  logic                  i_rd_zero,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(1 << DEPTH_LOG2)-1];
    logic [31:0] r_rdata;

    // Byte-lane writes; stored words survive reset and start undefined.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Registered read port; the zero request covers out-of-window reads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata <= 32'h0000_0000;
        end else if (i_rd_en) begin
            r_rdata <= i_rd_zero ? 32'h0000_0000 : r_mem[i_raddr];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder backed by a local word array. Independent read and
// write state machines; every output comes straight from a register.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [2:0]  s_arprot,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [2:0]  s_awprot,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready
);

    localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;

    // Read path
    rstate_t     r_rstate;
    logic        r_arready;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic        w_ar_hs;
    logic        w_ar_ok;
    logic [31:0] w_ar_off;
    logic [31:0] w_rdata;

    // Write path
    wstate_t     r_wstate;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_commit;
    logic [31:0] w_cm_addr;
    logic [31:0] w_cm_data;
    logic [3:0]  w_cm_strb;
    logic [31:0] w_cm_off;
    logic        w_cm_ok;
    logic [3:0]  w_we;
    logic        w_unused;

    assign w_ar_hs  = s_arvalid & r_arready;
    assign w_ar_ok  = addr_in_range(s_araddr, BASE, SPAN);
    assign w_ar_off = s_araddr - BASE;

    assign w_aw_hs  = s_awvalid & r_awready;
    assign w_w_hs   = s_wvalid & r_wready;
    assign w_cm_ok  = addr_in_range(w_cm_addr, BASE, SPAN);
    assign w_cm_off = w_cm_addr - BASE;
    assign w_we     = w_cm_strb & {4{w_commit & w_cm_ok}};

    // Protection bits and the sub-word offset bits carry no meaning here.
    assign w_unused = ^{s_arprot, s_awprot, w_ar_off[1:0], w_ar_off[31:DEPTH_LOG2+2],
                        w_cm_off[1:0], w_cm_off[31:DEPTH_LOG2+2]};

    // Read FSM: accept one address, present the response until rready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rresp   <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Pick the address/data halves that complete a write this cycle.
    always_comb begin
        w_commit  = 1'b0;
        w_cm_addr = s_awaddr;
        w_cm_data = s_wdata;
        w_cm_strb = s_wstrb;
        case (r_wstate)
            W_IDLE: begin
                w_commit = w_aw_hs & w_w_hs;
            end
            W_GOT_AW: begin
                w_cm_addr = r_awaddr;
                w_commit  = w_w_hs;
            end
            W_GOT_W: begin
                w_cm_data = r_wdata;
                w_cm_strb = r_wstrb;
                w_commit  = w_aw_hs;
            end
            default: begin
                w_commit = 1'b0;
            end
        endcase
    end

    // Write FSM: collect AW and W in either order, commit, then hold B.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= 32'h0000_0000;
            r_wdata   <= 32'h0000_0000;
            r_wstrb   <= 4'h0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_cm_ok ? RESP_OKAY : RESP_SLVERR;
                    end else if (w_aw_hs) begin
                        r_wstate  <= W_GOT_AW;
                        r_awaddr  <= s_awaddr;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wstate  <= W_GOT_W;
                        r_wdata   <= s_wdata;
                        r_wstrb   <= s_wstrb;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_GOT_AW, W_GOT_W: begin
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_cm_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    axi_lite_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk       (clk),
        .rstn      (rstn),
        .i_we      (w_we),
        .i_waddr   (w_cm_off[DEPTH_LOG2+1:2]),
        .i_wdata   (w_cm_data),
        .i_rd_en   (w_ar_hs),
        .i_rd_zero (~w_ar_ok),
        .i_raddr   (w_ar_off[DEPTH_LOG2+1:2]),
        .o_rdata   (w_rdata)
    );

    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rresp   = r_rresp;
    assign s_rdata   = w_rdata;
    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;

endmodule
